// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FSM state type and saturation bound helpers for mac_vec
package mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_HOLD
  } state_t;

  // Bounds are built in 64 bits and truncated by the caller to the accumulator width.
  function automatic logic [63:0] sat_max(input int width, input bit sgn);
    if (sgn) return (64'd1 << (width - 1)) - 64'd1;
    else if (width >= 64) return '1;
    else return (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width, input bit sgn);
    if (sgn) return ~((64'd1 << (width - 1)) - 64'd1);
    else return '0;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one MAC lane: registered product, saturating accumulator, sticky ovf
module mac_lane
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED_MODE != 0));

  logic [PW-1:0]        prod;
  logic                 prod_vld;
  logic [PW-1:0]        mult;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 sat_hit;
  logic [ACC_WIDTH-1:0] sat_val;

  generate
    if (SIGNED_MODE != 0) begin : g_signed
      localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1));
      // Low PW bits of the product of sign-extended operands equal the signed product.
      assign mult    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
      assign ext     = ACC_WIDTH'($signed(prod));
      assign sum     = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
      assign sat_hit = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      assign sat_val = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin : g_unsigned
      assign mult    = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      assign ext     = ACC_WIDTH'(prod);
      assign sum     = {1'b0, acc} + {1'b0, ext};
      assign sat_hit = sum[ACC_WIDTH];
      assign sat_val = ACC_MAX;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else if (clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      prod_vld <= load;
      if (load) prod <= mult;
      if (prod_vld) begin
        if (sat_hit) begin
          acc <= sat_val;
          ovf <= 1'b1;
        end else begin
          acc <= sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/mac_vec.sv
// rtl/mac_vec.sv - vector MAC: beat counter, result handshake FSM, LANES parallel lanes
module mac_vec
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int VEC_LEN     = 8,
  parameter int ACC_WIDTH   = DATA_WIDTH * 3,
  parameter int SIGNED_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] ain,
  input  logic [LANES*DATA_WIDTH-1:0] bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  cout,
  output logic [LANES-1:0]            ovf
);

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          hs;
  logic          lane_clr;

  assign in_ready  = (state == S_IDLE) || (state == S_ACCUM);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready && !clr;
  assign hs        = (state == S_HOLD) && out_ready;
  // A completed handshake empties the lanes so the next vector starts from zero.
  assign lane_clr  = clr || hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (clr) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_FLUSH;
            end else begin
              cnt   <= CW'(cnt + 1'b1);
              state <= S_ACCUM;
            end
          end
        end
        S_FLUSH: state <= S_HOLD;
        S_HOLD:  if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED_MODE(SIGNED_MODE)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (lane_clr),
        .load(accept),
        .a   (ain[i*DATA_WIDTH +: DATA_WIDTH]),
        .b   (bin[i*DATA_WIDTH +: DATA_WIDTH]),
        .acc (cout[i*ACC_WIDTH +: ACC_WIDTH]),
        .ovf (ovf[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mac_vec.sv
// tb/tb_mac_vec.sv - scoreboard bench: unsigned/24b, signed/24b and unsigned/16b instances share stimulus
module tb_mac_vec;

  logic        clk = 0, rst = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [15:0] ain = '0, bin = '0;

  logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s, in_ready_z, out_valid_z;
  logic [47:0] cout_u, cout_s;
  logic [31:0] cout_z;
  logic [1:0]  ovf_u, ovf_s, ovf_z;

  mac_vec #(.DATA_WIDTH(8), .LANES(2), .VEC_LEN(4), .ACC_WIDTH(24), .SIGNED_MODE(0)) u_uns (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_u), .ain(ain), .bin(bin),
    .out_valid(out_valid_u), .out_ready(out_ready), .cout(cout_u), .ovf(ovf_u));
  mac_vec #(.DATA_WIDTH(8), .LANES(2), .VEC_LEN(4), .ACC_WIDTH(24), .SIGNED_MODE(1)) u_sgn (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s), .ain(ain), .bin(bin),
    .out_valid(out_valid_s), .out_ready(out_ready), .cout(cout_s), .ovf(ovf_s));
  mac_vec #(.DATA_WIDTH(8), .LANES(2), .VEC_LEN(4), .ACC_WIDTH(16), .SIGNED_MODE(0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_z), .ain(ain), .bin(bin),
    .out_valid(out_valid_z), .out_ready(out_ready), .cout(cout_z), .ovf(ovf_z));

  typedef struct {
    logic [47:0] cu;
    logic [47:0] cs;
    logic [31:0] cz;
    logic [1:0]  ou;
    logic [1:0]  os;
    logic [1:0]  oz;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0, errors = 0, cyc = 0, last_beat = 0;
  logic ov_prev = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [47:0] cu, input logic [47:0] cs, input logic [31:0] cz,
                      input logic [1:0] ou, input logic [1:0] os, input logic [1:0] oz);
    exp_t x;
    x.cu = cu; x.cs = cs; x.cz = cz; x.ou = ou; x.os = os; x.oz = oz;
    sb.push_back(x);
  endtask

  task automatic beat(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1, input logic [7:0] b1);
    @(negedge clk);
    in_valid = 1; ain = {a1, a0}; bin = {b1, b0};
    chk("in_ready_beat", 64'(in_ready_u), 64'd1);
    last_beat = cyc;
  endtask

  task automatic vec4(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1, input logic [7:0] b1,
                      input bit gap);
    for (int i = 0; i < 4; i++) begin
      beat(a0, b0, a1, b1);
      if (gap) begin
        @(negedge clk);
        in_valid = 0;
      end
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!out_valid_u && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid_u;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic handshake(input int stall, input logic [47:0] hold_cu);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      for (int i = 0; i < stall; i++) begin
        chk("in_ready_hold", 64'(in_ready_u), 64'd0);
        chk("cout_hold", 64'(cout_u), 64'(hold_cu));
        @(negedge clk);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("in_ready_after_hs", 64'(in_ready_u), 64'd1);
      chk("out_valid_after_hs", 64'(out_valid_u), 64'd0);
      chk("cout_u_cleared", 64'(cout_u), 64'd0);
      chk("cout_z_cleared", 64'(cout_z), 64'd0);
      chk("ovf_z_cleared", 64'(ovf_z), 64'd0);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge of out_valid.
  always @(negedge clk) begin
    if (out_valid_u && !ov_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out_valid=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk("cout_uns", 64'(cout_u), 64'(e.cu));
        chk("cout_sgn", 64'(cout_s), 64'(e.cs));
        chk("cout_sat", 64'(cout_z), 64'(e.cz));
        chk("ovf_uns", 64'(ovf_u), 64'(e.ou));
        chk("ovf_sgn", 64'(ovf_s), 64'(e.os));
        chk("ovf_sat", 64'(ovf_z), 64'(e.oz));
        chk("result_latency", 64'(cyc - last_beat), 64'd2);
      end
    end
    ov_prev = out_valid_u;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bit ok;
    #2 rst = 1;
    #2;
    chk("rst_out_valid", 64'(out_valid_u), 64'd0);
    chk("rst_cout", 64'(cout_u), 64'd0);
    chk("rst_ovf", 64'(ovf_z), 64'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready_u), 64'd1);

    // 3*5=15 x4 = 60; 10*10=100 x4 = 400
    push({24'd400, 24'd60}, {24'd400, 24'd60}, {16'd400, 16'd60}, 2'b00, 2'b00, 2'b00);
    vec4(8'd3, 8'd5, 8'd10, 8'd10, 0);
    handshake(5, {24'd400, 24'd60});

    // 0xFE*7: unsigned 254*7*4 = 7112 = 0x1BC8; signed -2*7*4 = -56
    push({24'h001BC8, 24'h001BC8}, {24'hFFFFC8, 24'hFFFFC8}, {16'h1BC8, 16'h1BC8}, 2'b00, 2'b00, 2'b00);
    vec4(8'hFE, 8'd7, 8'hFE, 8'd7, 0);
    handshake(0, {24'h001BC8, 24'h001BC8});

    // 255*255*4 = 260100 = 0x3F804 (24b); signed (-1)(-1)*4 = 4; 16b saturates at 0xFFFF
    push({24'h03F804, 24'h03F804}, {24'd4, 24'd4}, {16'hFFFF, 16'hFFFF}, 2'b00, 2'b00, 2'b11);
    vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    handshake(1, {24'h03F804, 24'h03F804});

    // clr discards two 1*1 beats and an in-flight beat; then 4 beats of 2*3 with gaps -> 24
    beat(8'd1, 8'd1, 8'd1, 8'd1);
    beat(8'd1, 8'd1, 8'd1, 8'd1);
    @(negedge clk);
    clr = 1; ain = 16'h0909; bin = 16'h0909;
    @(negedge clk);
    clr = 0; in_valid = 0;
    chk("cout_after_clr", 64'(cout_u), 64'd0);
    push({24'd24, 24'd24}, {24'd24, 24'd24}, {16'd24, 16'd24}, 2'b00, 2'b00, 2'b00);
    vec4(8'd2, 8'd3, 8'd2, 8'd3, 1);
    handshake(0, {24'd24, 24'd24});

    // rst while holding a result
    push({24'd400, 24'd60}, {24'd400, 24'd60}, {16'd400, 16'd60}, 2'b00, 2'b00, 2'b00);
    vec4(8'd3, 8'd5, 8'd10, 8'd10, 0);
    wait_valid(ok);
    #2 rst = 1;
    #1;
    chk("rst_hold_out_valid", 64'(out_valid_u), 64'd0);
    chk("rst_hold_cout_u", 64'(cout_u), 64'd0);
    chk("rst_hold_cout_s", 64'(cout_s), 64'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst_hold", 64'(in_ready_u), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_vec.md
MAC_VEC -- requirements
Module: mac_vec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width per lane.
REQ-002 SHALL have parameter LANES, default 4, independent MAC lanes.
REQ-003 SHALL have parameter VEC_LEN, default 8, accepted beats per result (>=1).
REQ-004 SHALL have parameter ACC_WIDTH, default DATA_WIDTH*3, accumulator width per lane (>=2*DATA_WIDTH).
REQ-005 SHALL have parameter SIGNED_MODE, default 0; 1 = two's-complement operands and accumulators.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port clr  input  1  synchronous abort/clear.
REQ-009 SHALL have port in_valid  input  1  operand beat valid.
REQ-010 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 SHALL have port ain  input  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port bin  input  LANES*DATA_WIDTH  same packing as ain.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port cout  output  LANES*ACC_WIDTH  per-lane accumulated result.
REQ-016 SHALL have port ovf  output  LANES  per-lane sticky saturation flag.

Function
REQ-017 SHALL run FSM IDLE -> ACCUM -> FLUSH -> HOLD -> IDLE.
REQ-018 IDLE/ACCUM: in_ready=1; each accepted beat registers LANES products (stage 1) and increments beat counter.
REQ-019 Registered product SHALL be added to its accumulator on the next edge (stage 2).
REQ-020 First accepted beat SHALL move IDLE->ACCUM; gaps in in_valid SHALL be tolerated with no counter change.
REQ-021 Accepting beat VEC_LEN (counter VEC_LEN-1) SHALL move to FLUSH and wrap counter to 0.
REQ-022 FLUSH SHALL last exactly one cycle, in_ready=0, then HOLD; last beat accepted in cycle T gives out_valid=1 in cycle T+2.
REQ-023 HOLD: out_valid=1, in_ready=0, cout/ovf stable until out_valid && out_ready.
REQ-024 Handshake in HOLD SHALL clear accumulators and ovf and enter IDLE next cycle (in_ready=1).
REQ-025 Products SHALL be 2*DATA_WIDTH, sign-extended (SIGNED_MODE=1) or zero-extended (0) to ACC_WIDTH.
REQ-026 Accumulation overflow SHALL clamp to max/min of the ACC_WIDTH signed or unsigned range and set that lane's ovf until cleared.
REQ-027 clr SHALL override all other inputs: next cycle IDLE, counter, product valid, accumulators, ovf all zero; an in-flight beat is discarded.
REQ-028 When VEC_LEN=1, an accepted beat in IDLE SHALL go directly to FLUSH.

Reset
REQ-029 rst asserted SHALL immediately force IDLE, counter 0, accumulators 0, product stage invalid, out_valid=0, cout=0, ovf=0.
REQ-030 in_ready SHALL be 1 from the first cycle after rst deasserts; rst mid-vector or mid-HOLD discards all state.

Structure
REQ-031 Package mac_pkg SHALL hold the FSM state enum typedef and saturation min/max constant functions.
REQ-032 Sub-module mac_lane SHALL implement one lane (product register, saturating accumulator, ovf), instantiated LANES times by generate; mac_vec holds FSM, counter, handshake.

Verification (LANES=2, DATA_WIDTH=8, VEC_LEN=4 unless stated)
REQ-033 Unsigned: lane0 a=3,b=5, lane1 a=10,b=10, 4 back-to-back beats -> cout lane0=60, lane1=400, out_valid 2 cycles after 4th beat, ovf=0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> cout unchanged, in_ready=0; handshake -> in_ready=1 next cycle, accumulators 0.
REQ-035 Signed (SIGNED_MODE=1): a=0xFE(-2), b=7, 4 beats -> lane cout=0xFFFFC8 (-56).
REQ-036 Saturation (ACC_WIDTH=16, unsigned): a=b=255, 4 beats -> cout=0xFFFF, ovf=1; ovf cleared after handshake.
REQ-037 clr after 2 beats of a=1,b=1, then 4 beats a=2,b=3 -> cout=24 (pre-clr beats excluded).
REQ-038 rst pulse while in HOLD -> out_valid=0, cout=0 immediately; in_ready=1 after rst deasserts.
